// File: rtl/rv_tag_pkg.sv
// Shared widths and types for register renaming with dispatch tags.
// Both the tag FIFO and the status table size their tags from here.
package rv_tag_pkg;

    localparam int TAG_WIDTH      = 6;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_ARCH_REGS  = 32;

    typedef logic [TAG_WIDTH-1:0]      tag_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/rst_read_port.sv
// One source-operand lookup of the register status table, including the
// CDB bypass that makes a just-broadcast result usable in the same cycle.
module rst_read_port #(
    parameter int TAG_WIDTH = rv_tag_pkg::TAG_WIDTH
) (
    input  logic                 pending_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 cdb_valid_i,
    input  logic [TAG_WIDTH-1:0] cdb_tag_i,
    output logic                 valid_o,
    output logic                 fwd_o,
    output logic [TAG_WIDTH-1:0] tag_o
);

    logic hit;

    assign hit     = pending_i & cdb_valid_i & (tag_i == cdb_tag_i);
    assign valid_o = ~pending_i | hit;
    assign fwd_o   = hit;
    // Consumers rely on a zero tag for operands that are not waiting.
    assign tag_o   = pending_i ? tag_i : '0;

endmodule

// File: rtl/reg_status_table.sv
// Register status table: renames destinations to free tags, reports source
// operand readiness, and retires mappings when their tag appears on the CDB.
module reg_status_table #(
    parameter int NUM_REGS  = rv_tag_pkg::NUM_ARCH_REGS,
    parameter int TAG_WIDTH = rv_tag_pkg::TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dispatch_valid_rst,
    input  logic                 rd_we_rst,
    input  logic [4:0]           rd_rst,
    input  logic [4:0]           rs1_rst,
    input  logic [4:0]           rs2_rst,
    input  logic [TAG_WIDTH-1:0] tagin_rst,
    input  logic                 ef_tf,
    output logic                 ren_tf,
    output logic                 stall_rst,
    output logic [TAG_WIDTH-1:0] rs1_tag_rst,
    output logic [TAG_WIDTH-1:0] rs2_tag_rst,
    output logic                 rs1_valid_rst,
    output logic                 rs2_valid_rst,
    output logic                 rs1_fwd_rst,
    output logic                 rs2_fwd_rst,
    input  logic [TAG_WIDTH-1:0] cdb_tag_rst,
    input  logic                 cdb_valid_rst,
    output logic                 rf_we_rst,
    output logic [4:0]           rf_waddr_rst
);
    import rv_tag_pkg::*;

    // Tag FIFO handshake: ef_tf=0 means tagin_rst holds a valid free tag this
    // cycle; ren_tf=1 consumes it on the same edge. ren_tf never rises with ef_tf=1.

    logic [NUM_REGS-1:1]  pending_q, pending_d;
    logic [TAG_WIDTH-1:0] tag_q [1:NUM_REGS-1];
    logic [TAG_WIDTH-1:0] tag_d [1:NUM_REGS-1];

    logic [NUM_REGS-1:0]  pend_vec;
    logic [TAG_WIDTH-1:0] tag_vec [NUM_REGS];
    logic [NUM_REGS-1:0]  match_vec;
    logic                 need, alloc;
    reg_addr_t            waddr;

    // x0 reads as never pending; during reset every entry reads as idle.
    always_comb begin
        pend_vec   = '0;
        tag_vec[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            pend_vec[r] = pending_q[r] & ~rst;
            tag_vec[r]  = rst ? '0 : tag_q[r];
        end
    end

    assign need      = dispatch_valid_rst & rd_we_rst & (rd_rst != '0) & ~rst;
    assign alloc     = need & ~ef_tf;
    assign ren_tf    = alloc;
    assign stall_rst = need & ef_tf;

    always_comb begin
        match_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            match_vec[r] = pend_vec[r] & cdb_valid_rst & (tag_vec[r] == cdb_tag_rst);
        end
    end

    // Tags are unique, so match_vec is at most one-hot and an OR-encoder suffices.
    always_comb begin
        waddr = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (match_vec[r]) begin
                waddr = waddr | REG_ADDR_WIDTH'(r);
            end
        end
    end

    assign rf_we_rst    = |match_vec;
    assign rf_waddr_rst = waddr;

    // Allocation is applied after retire so a same-cycle rename of the
    // retiring register keeps the new mapping.
    always_comb begin
        pending_d = pending_q;
        tag_d     = tag_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (match_vec[r]) begin
                pending_d[r] = 1'b0;
            end
            if (alloc && (rd_rst == REG_ADDR_WIDTH'(r))) begin
                pending_d[r] = 1'b1;
                tag_d[r]     = tagin_rst;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            tag_q     <= tag_d;
        end
    end

    rst_read_port #(.TAG_WIDTH(TAG_WIDTH)) u_rs1 (
        .pending_i   (pend_vec[rs1_rst]),
        .tag_i       (tag_vec[rs1_rst]),
        .cdb_valid_i (cdb_valid_rst),
        .cdb_tag_i   (cdb_tag_rst),
        .valid_o     (rs1_valid_rst),
        .fwd_o       (rs1_fwd_rst),
        .tag_o       (rs1_tag_rst)
    );

    rst_read_port #(.TAG_WIDTH(TAG_WIDTH)) u_rs2 (
        .pending_i   (pend_vec[rs2_rst]),
        .tag_i       (tag_vec[rs2_rst]),
        .cdb_valid_i (cdb_valid_rst),
        .cdb_tag_i   (cdb_tag_rst),
        .valid_o     (rs2_valid_rst),
        .fwd_o       (rs2_fwd_rst),
        .tag_o       (rs2_tag_rst)
    );

endmodule

// File: tb/tb_reg_status_table.sv
// Self-checking bench for reg_status_table: directed scenarios plus a
// randomized phase, every cycle scored against a reference model.
module tb_reg_status_table;

    localparam int W = 24;

    logic       clk;
    logic       rst;
    logic       dispatch_valid_rst, rd_we_rst;
    logic [4:0] rd_rst, rs1_rst, rs2_rst;
    logic [5:0] tagin_rst;
    logic       ef_tf;
    logic       ren_tf, stall_rst;
    logic [5:0] rs1_tag_rst, rs2_tag_rst;
    logic       rs1_valid_rst, rs2_valid_rst, rs1_fwd_rst, rs2_fwd_rst;
    logic [5:0] cdb_tag_rst;
    logic       cdb_valid_rst;
    logic       rf_we_rst;
    logic [4:0] rf_waddr_rst;

    reg_status_table dut (
        .clk                (clk),
        .rst                (rst),
        .dispatch_valid_rst (dispatch_valid_rst),
        .rd_we_rst          (rd_we_rst),
        .rd_rst             (rd_rst),
        .rs1_rst            (rs1_rst),
        .rs2_rst            (rs2_rst),
        .tagin_rst          (tagin_rst),
        .ef_tf              (ef_tf),
        .ren_tf             (ren_tf),
        .stall_rst          (stall_rst),
        .rs1_tag_rst        (rs1_tag_rst),
        .rs2_tag_rst        (rs2_tag_rst),
        .rs1_valid_rst      (rs1_valid_rst),
        .rs2_valid_rst      (rs2_valid_rst),
        .rs1_fwd_rst        (rs1_fwd_rst),
        .rs2_fwd_rst        (rs2_fwd_rst),
        .cdb_tag_rst        (cdb_tag_rst),
        .cdb_valid_rst      (cdb_valid_rst),
        .rf_we_rst          (rf_we_rst),
        .rf_waddr_rst       (rf_waddr_rst)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           total = 0;
    int           bad   = 0;

    logic       m_pend [32];
    logic [5:0] m_tag  [32];

    logic       o_ren, o_stall, o_v1, o_f1, o_v2, o_f2, o_we;
    logic [5:0] o_t1, o_t2;
    logic [4:0] o_wa;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic model_lookup(input logic [4:0] s, input logic cv, input logic [5:0] ct,
                                output logic v, output logic f, output logic [5:0] t);
        if (s == 5'd0 || !m_pend[s]) begin
            v = 1'b1; f = 1'b0; t = 6'd0;
        end else begin
            f = cv && (m_tag[s] == ct);
            v = f;
            t = m_tag[s];
        end
    endtask

    // driver: one cycle of stimulus, expectation pushed, output popped at negedge
    task automatic step(input logic r, input logic dv, input logic we, input logic [4:0] rd,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [5:0] tin,
                        input logic ef, input logic cv, input logic [5:0] ct);
        logic       e_ren, e_stall, e_v1, e_f1, e_v2, e_f2, e_we, need;
        logic [5:0] e_t1, e_t2;
        logic [4:0] e_wa;
        logic [W-1:0] e;
        rst = r; dispatch_valid_rst = dv; rd_we_rst = we; rd_rst = rd;
        rs1_rst = s1; rs2_rst = s2; tagin_rst = tin; ef_tf = ef;
        cdb_valid_rst = cv; cdb_tag_rst = ct;
        e_we = 1'b0; e_wa = 5'd0;
        if (r) begin
            e_ren = 0; e_stall = 0; e_v1 = 1; e_f1 = 0; e_t1 = 0; e_v2 = 1; e_f2 = 0; e_t2 = 0;
        end else begin
            need    = dv && we && (rd != 5'd0);
            e_ren   = need && !ef;
            e_stall = need && ef;
            model_lookup(s1, cv, ct, e_v1, e_f1, e_t1);
            model_lookup(s2, cv, ct, e_v2, e_f2, e_t2);
            for (int i = 1; i < 32; i++) begin
                if (cv && m_pend[i] && m_tag[i] == ct) begin
                    e_we = 1'b1; e_wa = 5'(i);
                end
            end
        end
        exp_q.push_back({e_ren, e_stall, e_v1, e_f1, e_t1, e_v2, e_f2, e_t2, e_we, e_wa});
        @(negedge clk);
        o_ren = ren_tf; o_stall = stall_rst; o_v1 = rs1_valid_rst; o_f1 = rs1_fwd_rst;
        o_t1 = rs1_tag_rst; o_v2 = rs2_valid_rst; o_f2 = rs2_fwd_rst; o_t2 = rs2_tag_rst;
        o_we = rf_we_rst; o_wa = rf_waddr_rst;
        e = exp_q.pop_front();
        chk("ren_tf",   32'(o_ren),   32'(e[23]));
        chk("stall",    32'(o_stall), 32'(e[22]));
        chk("rs1_val",  32'(o_v1),    32'(e[21]));
        chk("rs1_fwd",  32'(o_f1),    32'(e[20]));
        chk("rs1_tag",  32'(o_t1),    32'(e[19:14]));
        chk("rs2_val",  32'(o_v2),    32'(e[13]));
        chk("rs2_fwd",  32'(o_f2),    32'(e[12]));
        chk("rs2_tag",  32'(o_t2),    32'(e[11:6]));
        chk("rf_we",    32'(o_we),    32'(e[5]));
        chk("rf_waddr", 32'(o_wa),    32'(e[4:0]));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_pend[i] = 1'b0; m_tag[i] = 6'd0;
            end
        end else begin
            if (e_we) m_pend[e_wa] = 1'b0;
            if (e_ren) begin
                m_pend[rd] = 1'b1; m_tag[rd] = tin;
            end
        end
        #1;
    endtask

    // read-only cycle helper
    task automatic rd2(input logic [4:0] s1, input logic [4:0] s2);
        step(0, 0, 0, 5'd0, s1, s2, 6'd0, 0, 0, 6'd0);
    endtask

    function automatic logic tag_busy(input logic [5:0] t);
        logic b = 1'b0;
        for (int i = 1; i < 32; i++) if (m_pend[i] && m_tag[i] == t) b = 1'b1;
        return b;
    endfunction

    logic [5:0] next_tag;

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 1'b1; m_tag[i] = 6'h3F;
        end
        rst = 1; dispatch_valid_rst = 0; rd_we_rst = 0; rd_rst = 0; rs1_rst = 0; rs2_rst = 0;
        tagin_rst = 0; ef_tf = 0; cdb_valid_rst = 0; cdb_tag_rst = 0;
        @(posedge clk); #1;

        // reset with a live dispatch: outputs must stay quiet
        step(1, 1, 1, 5'd5, 5'd5, 5'd6, 6'h2A, 0, 1, 6'h2A);
        chk("rst_ren", 32'(o_ren), 32'd0);
        step(1, 0, 0, 5'd0, 5'd5, 5'd0, 6'h00, 0, 0, 6'h00);

        rd2(5'd5, 5'd0);
        chk("read_v1", 32'(o_v1), 32'd1);
        chk("read_t1", 32'(o_t1), 32'd0);

        // allocate x5 -> 0x2A, then see it pending
        step(0, 1, 1, 5'd5, 5'd1, 5'd2, 6'h2A, 0, 0, 6'h00);
        chk("alloc_ren", 32'(o_ren), 32'd1);
        rd2(5'd5, 5'd0);
        chk("pend_v1", 32'(o_v1), 32'd0);
        chk("pend_t1", 32'(o_t1), 32'h2A);

        // retire with bypass
        step(0, 0, 0, 5'd0, 5'd5, 5'd0, 6'h00, 0, 1, 6'h2A);
        chk("byp_fwd", 32'(o_f1), 32'd1);
        chk("byp_wa",  32'(o_wa), 32'd5);
        rd2(5'd5, 5'd0);
        chk("ret_v1", 32'(o_v1), 32'd1);
        chk("ret_f1", 32'(o_f1), 32'd0);

        // stale tag
        step(0, 1, 1, 5'd5, 5'd0, 5'd0, 6'h2A, 0, 0, 6'h00);
        step(0, 1, 1, 5'd5, 5'd0, 5'd0, 6'h11, 0, 0, 6'h00);
        step(0, 0, 0, 5'd0, 5'd5, 5'd0, 6'h00, 0, 1, 6'h2A);
        chk("stale_we", 32'(o_we), 32'd0);
        rd2(5'd5, 5'd5);
        chk("stale_t1", 32'(o_t1), 32'h11);
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 6'h00, 0, 1, 6'h11);

        // empty FIFO stall, then x0 destination
        step(0, 1, 1, 5'd7, 5'd7, 5'd0, 6'h05, 1, 0, 6'h00);
        chk("ef_stall", 32'(o_stall), 32'd1);
        chk("ef_ren",   32'(o_ren),   32'd0);
        rd2(5'd7, 5'd0);
        chk("ef_nochg", 32'(o_v1), 32'd1);
        step(0, 1, 1, 5'd0, 5'd0, 5'd0, 6'h06, 0, 0, 6'h00);
        chk("x0_ren", 32'(o_ren), 32'd0);

        // collision: rename x9 while its old tag retires
        step(0, 1, 1, 5'd9, 5'd0, 5'd0, 6'h08, 0, 0, 6'h00);
        step(0, 1, 1, 5'd9, 5'd9, 5'd0, 6'h03, 0, 1, 6'h08);
        chk("col_we",  32'(o_we), 32'd1);
        chk("col_wa",  32'(o_wa), 32'd9);
        chk("col_old", 32'(o_t1), 32'h08);
        rd2(5'd9, 5'd9);
        chk("col_new", 32'(o_t1), 32'h03);
        chk("col_pend", 32'(o_v1), 32'd0);

        // mid-operation reset discards mappings
        step(1, 0, 0, 5'd0, 5'd9, 5'd0, 6'h00, 0, 0, 6'h00);
        rd2(5'd9, 5'd0);
        chk("mrst_v1", 32'(o_v1), 32'd1);

        // randomized phase with unique in-flight tags
        next_tag = 6'd1;
        for (int n = 0; n < 400; n++) begin
            logic       cv;
            logic [5:0] ct;
            logic [4:0] rd, s1, s2;
            int         pick;
            while (tag_busy(next_tag)) next_tag = next_tag + 6'd1;
            cv = 1'b0; ct = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 7) begin
                pick = $urandom_range(1, 31);
                for (int k = 0; k < 31; k++) begin
                    int j = ((pick + k - 1) % 31) + 1;
                    if (!cv && m_pend[j]) begin
                        cv = 1'b1; ct = m_tag[j];
                    end
                end
            end else if ($urandom_range(0, 1) == 1) begin
                cv = 1'b1;
                if (tag_busy(ct)) ct = next_tag;
            end
            rd = 5'($urandom_range(0, 31));
            s1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            s2 = 5'($urandom_range(0, 31));
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), rd, s1, s2,
                 next_tag, 1'($urandom_range(0, 6) == 0), cv, ct);
            next_tag = next_tag + 6'd1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
